operand_loader: RTL and testbench
=================================

// Module: operand_loader
// PURPOSE
//  Word-serial front/back end for the 1024-bit accelerator. Collects 32-bit words from a
//  valid/ready input stream into one 1024-bit operand, clears and starts the accelerator,
//  waits for done, captures the 1024-bit result and streams it out as 32-bit words.
//  Sits between the bus/DMA side and the accelerator's start/din/dout/done interface.
// PARAMETERS
//  DW           1024  operand/result width; must equal the accelerator data width
//  WW           32    stream word width; NW = DW/WW (localparam, 32) words per operand
//  TIMEOUT_CYC  1024  WAIT-state cycle limit; used only when LOADER_TIMEOUT_EN is defined
// PORTS
//  clk         in   1    single clock, all logic rising-edge
//  resetn      in   1    asynchronous active-low reset
//  s_data      in   WW   input word
//  s_valid     in   1    input word valid
//  s_ready     out  1    input word accepted when s_valid & s_ready
//  m_data      out  WW   output word
//  m_valid     out  1    output word valid
//  m_ready     in   1    output word consumed when m_valid & m_ready
//  m_last      out  1    high with the final (NW-1) output word
//  acc_din     out  DW   operand to accelerator
//  acc_start   out  1    one-cycle start pulse to accelerator
//  acc_resetn  out  1    accelerator clear, active-low: resetn & (state != ST_CLR)
//  acc_dout    in   DW   accelerator result
//  acc_done    in   1    accelerator done (level; sticky until accelerator cleared)
//  busy        out  1    high in every state except ST_LOAD with word count 0
//  err         out  1    sticky timeout flag; cleared only by resetn
// BEHAVIOUR
//  Reset (async, resetn=0): state=ST_LOAD, counters=0, in/out regs=0, err=0;
//   s_ready=0, m_valid=0, m_last=0, acc_start=0, acc_resetn=0, busy=0. All partial data lost.
//  FSM: ST_LOAD -> ST_CLR -> ST_START -> ST_WAIT -> ST_UNLOAD -> ST_LOAD.
//  ST_LOAD: s_ready=1. Each handshake shifts s_data into in_reg MSB end (right shift), cnt++.
//   Word k of the stream ends at acc_din[WW*k+WW-1 : WW*k]. Handshake with cnt==NW-1 -> ST_CLR.
//  ST_CLR: exactly 1 cycle, acc_resetn=0 (clears stale acc_done). -> ST_START.
//  ST_START: exactly 1 cycle, acc_start=1. -> ST_WAIT.
//  ST_WAIT: acc_done sampled high -> out_reg <= acc_dout, cnt=0, -> ST_UNLOAD.
//  ST_UNLOAD: m_valid=1, m_data=out_reg[WW-1:0], m_last=(cnt==NW-1). Handshake shifts out_reg
//   right by WW, cnt++. Handshake with m_last -> ST_LOAD, cnt=0.
//  acc_din driven from in_reg continuously; stable from ST_CLR through ST_WAIT (s_ready=0).
//  Latency: m_valid rises the cycle after acc_done is first sampled high in ST_WAIT;
//   acc_start asserts 2 cycles after the last input handshake.
//  Backpressure: m_ready low holds m_data/m_last stable. m_ready without m_valid ignored.
//   s_valid outside ST_LOAD is ignored (no acceptance). No input/output overlap.
//  Counter: log2(NW)-bit; never wraps in operation (exits state at NW-1).
// CONFIGURATION
//  LOADER_TIMEOUT_EN defined: wait counter runs in ST_WAIT; reaching TIMEOUT_CYC cycles without
//   acc_done -> err<=1, result discarded, cnt=0, -> ST_LOAD. acc_done and expiry in the same
//   cycle: done wins, err unchanged. Counter cleared on ST_WAIT entry.
//  Not defined: no wait counter, ST_WAIT exits only on acc_done, err tied 0.
// STRUCTURE
//  Package loader_pkg: DW/WW defaults, NW, state encodings ST_LOAD..ST_UNLOAD, counter width.
//  Sub-module word_shift_reg (DW,WW): load-parallel / shift-right-by-WW register; two instances
//   (in_reg: serial in at MSB; out_reg: parallel load, serial out at LSB).
// TESTING (bench pairs DUT with accelerator model: done 2 cycles after start)
//  1. Feed words 0..31 = 32'h0000_0000+k, m_ready=1 -> acc_din[31:0]=0, [1023:992]=31; acc_start
//     2 cycles after word 31; 32 output words = model result LSW first; m_last on word 31 only.
//  2. Two back-to-back operands -> second waits for fresh done (acc_resetn low 1 cycle first);
//     second output matches second operand, never the stale first result.
//  3. s_valid toggled randomly, m_ready held 0 for 10 cycles mid-unload -> no lost/duplicated
//     words, m_data stable while stalled.
//  4. resetn pulsed low after 12 input words -> all outputs at reset values same cycle; next 32
//     words form a clean operand.
//  5. LOADER_TIMEOUT_EN, model never asserts done -> err=1 exactly TIMEOUT_CYC cycles after
//     ST_WAIT entry, s_ready=1 next cycle, no m_valid; err stays 1 until resetn.
//  6. LOADER_TIMEOUT_EN, done on the expiry cycle -> result unloaded, err=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared widths and FSM state encodings for the operand loader and its shift registers.
package loader_pkg;
   localparam int unsigned DW_DEF = 1024;
   localparam int unsigned WW_DEF = 32;
   localparam int unsigned NW_DEF = DW_DEF / WW_DEF;
   localparam int unsigned CW_DEF = $clog2(NW_DEF);

   localparam logic [2:0] ST_LOAD   = 3'd0;
   localparam logic [2:0] ST_CLR    = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_UNLOAD = 3'd4;
endpackage

// File: rtl/word_shift_reg.sv
// DW-bit register with parallel load and word-wide right shift (new word enters at the MSB end).
module word_shift_reg
   import loader_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned WW = WW_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          shift,
   input  logic [WW-1:0] shift_in,
   output logic [DW-1:0] q
);
   logic [DW-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load)       q_d = load_data;
      else if (shift) q_d = {shift_in, q_q[DW-1:WW]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) q_q <= '0;
      else         q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/operand_loader.sv
// Word-serial loader/unloader around the wide accelerator.
// Define LOADER_TIMEOUT_EN to add the ST_WAIT watchdog and sticky err flag.
module operand_loader
   import loader_pkg::*;
#(
   parameter int unsigned DW          = DW_DEF,
   parameter int unsigned WW          = WW_DEF,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [WW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [WW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic [DW-1:0] acc_din,
   output logic          acc_start,
   output logic          acc_resetn,
   input  logic [DW-1:0] acc_dout,
   input  logic          acc_done,
   output logic          busy,
   output logic          err
);
   localparam int unsigned NW  = DW / WW;
   localparam int unsigned CW  = $clog2(NW);
   localparam int unsigned WCW = $clog2(TIMEOUT_CYC) + 1;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_shift, out_load, out_shift;
   logic [DW-1:0] out_q;
   logic          cnt_last;

`ifdef LOADER_TIMEOUT_EN
   logic [WCW-1:0] wait_q, wait_d;
   logic           err_q, err_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYC);
   assign err = 1'b0;
`endif

   assign cnt_last = (cnt_q == CW'(NW - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_shift  = 1'b0;
      out_load  = 1'b0;
      out_shift = 1'b0;
`ifdef LOADER_TIMEOUT_EN
      wait_d    = wait_q;
      err_d     = err_q;
`endif
      case (state_q)
         ST_LOAD: begin
            if (s_valid) begin
               in_shift = 1'b1;
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = ST_CLR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_CLR:   state_d = ST_START;
         ST_START: begin
            state_d = ST_WAIT;
`ifdef LOADER_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         ST_WAIT: begin
            // done takes priority over an expiry landing in the same cycle
            if (acc_done) begin
               out_load = 1'b1;
               cnt_d    = '0;
               state_d  = ST_UNLOAD;
            end
`ifdef LOADER_TIMEOUT_EN
            else if (wait_q == WCW'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_LOAD;
            end else begin
               wait_d = wait_q + 1'b1;
            end
`endif
         end
         ST_UNLOAD: begin
            if (m_ready) begin
               out_shift = 1'b1;
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end
   assign err = err_q;
`endif

   word_shift_reg #(.DW(DW), .WW(WW)) u_in_reg (
      .clk       (clk),
      .resetn    (resetn),
      .load      (1'b0),
      .load_data ('0),
      .shift     (in_shift),
      .shift_in  (s_data),
      .q         (acc_din)
   );

   word_shift_reg #(.DW(DW), .WW(WW)) u_out_reg (
      .clk       (clk),
      .resetn    (resetn),
      .load      (out_load),
      .load_data (acc_dout),
      .shift     (out_shift),
      .shift_in  ('0),
      .q         (out_q)
   );

   // Upper result bits only reach m_data through the shift chain.
   logic unused_out;
   assign unused_out = ^out_q[DW-1:WW];

   // Gated with resetn so the handshake outputs read as idle while reset is held.
   assign s_ready    = resetn & (state_q == ST_LOAD);
   assign m_valid    = (state_q == ST_UNLOAD);
   assign m_last     = m_valid & cnt_last;
   assign m_data     = out_q[WW-1:0];
   assign acc_start  = (state_q == ST_START);
   assign acc_resetn = resetn & (state_q != ST_CLR);
   assign busy       = (state_q != ST_LOAD) | (cnt_q != '0);
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader paired with a simple accelerator model (result = din ^ key).
module tb_operand_loader;
   localparam int unsigned DW = 1024;
   localparam int unsigned WW = 32;
   localparam int unsigned NW = 32;
   localparam int unsigned T  = 20;

   logic          clk, resetn;
   logic [WW-1:0] s_data, m_data;
   logic          s_valid, s_ready, m_valid, m_ready, m_last;
   logic [DW-1:0] acc_din, acc_dout;
   logic          acc_start, acc_resetn, acc_done, busy, err;

   operand_loader #(.DW(DW), .WW(WW), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .resetn(resetn),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .acc_din(acc_din), .acc_start(acc_start), .acc_resetn(acc_resetn),
      .acc_dout(acc_dout), .acc_done(acc_done), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accelerator model: done rises mdl_dly cycles after start (0 = never), sticky until cleared.
   logic [DW-1:0] key, mdl_res;
   logic          mdl_done;
   int            mdl_pend, mdl_dly;

   always @(posedge clk) begin
      if (!acc_resetn) begin
         mdl_done <= 1'b0;
         mdl_pend <= 0;
      end else if (acc_start) begin
         mdl_res  <= acc_din ^ key;
         mdl_pend <= mdl_dly;
      end else if (mdl_pend != 0) begin
         mdl_pend <= mdl_pend - 1;
         if (mdl_pend == 1) mdl_done <= 1'b1;
      end
   end
   assign acc_done = mdl_done;
   assign acc_dout = mdl_res;

   int n_chk, n_fail;
   logic [31:0] w [NW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] expw(input int k);
      return w[k] ^ (32'hC0DE_0000 + 32'(k) * 32'd257);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input bit rnd, input int n);
      int k = 0;
      int budget = 2000;
      bit hs;
      while (k < n && budget > 0) begin
         s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = w[k];
         hs = s_valid && s_ready;
         tick();
         if (hs) k++;
         budget--;
      end
      s_valid = 1'b0;
      chk("send_words", 32'(k), 32'(n));
      if (n == NW) begin
         chk("clr_acc_resetn", acc_resetn, 1'b0);
         chk("clr_acc_start", acc_start, 1'b0);
         chk("clr_s_ready", s_ready, 1'b0);
         chk("clr_busy", busy, 1'b1);
         chk("din_w0", acc_din[31:0], w[0]);
         chk("din_w5", acc_din[WW*5 +: WW], w[5]);
         chk("din_w31", acc_din[1023:992], w[31]);
         tick();
         chk("start_pulse", acc_start, 1'b1);
         chk("start_acc_resetn", acc_resetn, 1'b1);
         tick();
         chk("start_one_cycle", acc_start, 1'b0);
      end
   endtask

   task automatic recv(input int stall_k);
      int k = 0;
      int budget = 500;
      int stall_left = 10;
      bit first = 1'b1;
      bit hs;
      logic pd1 = 1'b0, pd2 = 1'b0;
      m_ready = 1'b1;
      while (k < NW && budget > 0) begin
         hs = 1'b0;
         if (m_valid) begin
            if (first) begin
               chk("lat_done_prev", pd1, 1'b1);
               chk("lat_done_prev2", pd2, 1'b0);
               first = 1'b0;
            end
            chk("m_data", m_data, expw(k));
            chk("m_last", m_last, (k == NW - 1));
            chk("unload_s_ready", s_ready, 1'b0);
            if (k == stall_k && stall_left > 0) begin
               m_ready = 1'b0;
               stall_left--;
            end else begin
               m_ready = 1'b1;
            end
            hs = m_ready;
         end
         pd2 = pd1;
         pd1 = acc_done;
         tick();
         if (hs) k++;
         budget--;
      end
      m_ready = 1'b1;
      chk("recv_words", 32'(k), 32'(NW));
      chk("after_unload_valid", m_valid, 1'b0);
      chk("after_unload_busy", busy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      mdl_dly = 2;
      for (int k = 0; k < NW; k++) key[32*k +: 32] = 32'hC0DE_0000 + 32'(k) * 32'd257;
      resetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      #1;
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_acc_start", acc_start, 1'b0);
      chk("rst_acc_resetn", acc_resetn, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      #20 resetn = 1'b1;
      tick();
      chk("idle_s_ready", s_ready, 1'b1);

      // 1: counting pattern, m_ready held high
      m_ready = 1'b1;
      for (int k = 0; k < NW; k++) w[k] = 32'(k);
      send_op(1'b0, NW);
      recv(-1);

      // 2: back-to-back operands; junk s_valid during unload must be ignored
      for (int k = 0; k < NW; k++) w[k] = 32'hA5A5_0000 ^ (32'(k) << 8);
      send_op(1'b0, NW);
      s_valid = 1'b1; s_data = 32'hBAD0_BAD0;
      recv(-1);
      for (int k = 0; k < NW; k++) w[k] = 32'h5A5A_FFFF - 32'(k) * 32'd3;
      send_op(1'b0, NW);
      recv(-1);

      // 3: random input gaps and a 10-cycle output stall mid-unload
      for (int k = 0; k < NW; k++) w[k] = $urandom;
      send_op(1'b1, NW);
      recv(10);

      // 4: reset in the middle of loading
      for (int k = 0; k < NW; k++) w[k] = 32'h1000_0000 + 32'(k);
      send_op(1'b0, 12);
      chk("partial_busy", busy, 1'b1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_s_ready", s_ready, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_m_valid", m_valid, 1'b0);
      chk("mid_rst_acc_start", acc_start, 1'b0);
      chk("mid_rst_acc_resetn", acc_resetn, 1'b0);
      chk("mid_rst_din_hi", acc_din[1023:992], 32'h0);
      chk("mid_rst_err", err, 1'b0);
      #3 resetn = 1'b1;
      tick();
      for (int k = 0; k < NW; k++) w[k] = 32'h2000_0000 + 32'(k) * 32'd17;
      send_op(1'b0, NW);
      recv(-1);

`ifdef LOADER_TIMEOUT_EN
      // 6: done lands on the expiry cycle
      mdl_dly = T - 1;
      for (int k = 0; k < NW; k++) w[k] = 32'h3300_0000 + 32'(k);
      send_op(1'b0, NW);
      recv(-1);
      chk("expiry_done_err", err, 1'b0);

      // 5: done never arrives
      mdl_dly = 0;
      send_op(1'b0, NW);
      for (int j = 0; j < int'(T) - 1; j++) tick();
      chk("pre_timeout_err", err, 1'b0);
      chk("pre_timeout_s_ready", s_ready, 1'b0);
      tick();
      chk("timeout_err", err, 1'b1);
      chk("timeout_s_ready", s_ready, 1'b1);
      chk("timeout_m_valid", m_valid, 1'b0);
      for (int j = 0; j < 5; j++) tick();
      chk("err_sticky", err, 1'b1);
      chk("err_no_m_valid", m_valid, 1'b0);
      resetn = 1'b0;
      #1;
      chk("err_cleared", err, 1'b0);
      #3 resetn = 1'b1;
      mdl_dly = 2;
      tick();
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
